// File: rtl/core_axi_master.sv
// AXI4-Lite master: turns one valid/ready command into a single AW/W/B or AR/R
// transaction and returns the read data and response on a valid/ready port.
module core_axi_master #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 16
) (
   input  logic                              M_AXI_ACLK,
   input  logic                              M_AXI_ARST,
   // local command port
   input  logic                              CMD_VALID,
   output logic                              CMD_READY,
   input  logic                              CMD_WE,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_WSTRB,
   // local response port
   output logic                              RSP_VALID,
   input  logic                              RSP_READY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
   output logic [1:0]                        RSP_RESP,
   output logic                              BUSY,
   // AXI4-Lite write address / data / response
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   // AXI4-Lite read address / data
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WRESP,
      S_READ,
      S_RDATA,
      S_RESP
   } state_t;

   state_t                         r_state;
   logic                           r_cmd_ready;
   logic                           r_busy;
   logic                           r_rsp_valid;
   logic [C_M_AXI_DATA_WIDTH-1:0]  r_rsp_rdata;
   logic [1:0]                     r_rsp_resp;
   logic [C_M_AXI_ADDR_WIDTH-1:0]  r_addr;
   logic [C_M_AXI_DATA_WIDTH-1:0]  r_wdata;
   logic [STRB_W-1:0]              r_wstrb;
   logic                           r_awvalid;
   logic                           r_wvalid;
   logic                           r_bready;
   logic                           r_arvalid;
   logic                           r_rready;

   // A channel counts as done once its VALID has dropped or its handshake completes now.
   logic w_aw_done;
   logic w_w_done;
   assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
   assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

   assign CMD_READY     = r_cmd_ready;
   assign BUSY          = r_busy;
   assign RSP_VALID     = r_rsp_valid;
   assign RSP_RDATA     = r_rsp_rdata;
   assign RSP_RESP      = r_rsp_resp;
   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;

   // NOTE: every state register uses <= so all of them see pre-edge values this cycle.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARST) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (CMD_VALID && r_cmd_ready) begin
                  r_addr      <= CMD_ADDR;
                  r_wdata     <= CMD_WDATA;
                  r_wstrb     <= CMD_WSTRB;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  if (CMD_WE) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= S_WRITE;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_READ;
                  end
               end
            end

            S_WRITE: begin
               if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
               if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRESP;
               end
            end

            S_WRESP: begin
               if (M_AXI_BVALID) begin
                  r_rsp_resp  <= M_AXI_BRESP;
                  r_rsp_rdata <= '0;
                  r_bready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end

            S_READ: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RDATA;
               end
            end

            S_RDATA: begin
               if (M_AXI_RVALID) begin
                  r_rsp_rdata <= M_AXI_RDATA;
                  r_rsp_resp  <= M_AXI_RRESP;
                  r_rready    <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end

            S_RESP: begin
               if (RSP_READY) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_axi_master.sv
// Directed and randomized bench for core_axi_master: a behavioural AXI4-Lite slave
// plus a word-array reference of memory contents and per-edge latency checks.
module tb_core_axi_master;

   logic        M_AXI_ACLK = 1'b0;
   logic        M_AXI_ARST;
   logic        CMD_VALID, CMD_READY, CMD_WE;
   logic [15:0] CMD_ADDR;
   logic [31:0] CMD_WDATA;
   logic [3:0]  CMD_WSTRB;
   logic        RSP_VALID, RSP_READY, BUSY;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_RESP;
   logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
   logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic        M_AXI_RVALID, M_AXI_RREADY;

   int total = 0;
   int bad   = 0;

   core_axi_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(16)) dut (
      .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARST(M_AXI_ARST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
      .RSP_RESP(RSP_RESP), .BUSY(BUSY),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   initial forever #5 M_AXI_ACLK = ~M_AXI_ACLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- behavioural slave ----------------
   logic [31:0] s_mem   [0:31];
   logic [31:0] ref_mem [0:31];
   int   aw_delay = 0, w_delay = 0, r_delay = 0, b_delay = 0;
   bit   rnd = 0;
   logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   bit   s_rst = 0, s_aw_got = 0, s_w_got = 0, s_b_pend = 0, s_r_pend = 0;
   bit   hs_aw = 0, hs_w = 0, hs_ar = 0, hs_b = 0, hs_r = 0;
   int   aw_cnt = 0, w_cnt = 0, b_cnt = 0, r_cnt = 0;
   logic [15:0] s_awaddr = '0, s_araddr = '0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;

   function automatic bit gate(input int cnt, input int dly);
      if (rnd) return ($urandom_range(1, 0) == 1);
      return (cnt >= dly);
   endfunction

   always @(posedge M_AXI_ACLK) s_rst = M_AXI_ARST;

   // Slave acts on the falling edge: it consumes the handshakes of the last rising
   // edge, then decides what it presents for the next one.
   always @(negedge M_AXI_ACLK) begin
      if (s_rst) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
         M_AXI_BVALID = 0; M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
         s_aw_got = 0; s_w_got = 0; s_b_pend = 0; s_r_pend = 0;
         hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
         if (hs_aw) s_aw_got = 1;
         if (hs_w)  s_w_got  = 1;
         if (s_aw_got && s_w_got) begin
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b]) s_mem[s_awaddr[6:2]][b*8 +: 8] = s_wdata[b*8 +: 8];
            s_aw_got = 0; s_w_got = 0; s_b_pend = 1; b_cnt = 0;
         end
         if (hs_b) M_AXI_BVALID = 0;
         if (hs_ar) begin s_r_pend = 1; r_cnt = 0; end
         if (hs_r) M_AXI_RVALID = 0;

         if (M_AXI_AWVALID && !s_aw_got) begin
            M_AXI_AWREADY = gate(aw_cnt, aw_delay);
            if (!M_AXI_AWREADY) aw_cnt++;
         end else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
         if (M_AXI_WVALID && !s_w_got) begin
            M_AXI_WREADY = gate(w_cnt, w_delay);
            if (!M_AXI_WREADY) w_cnt++;
         end else begin M_AXI_WREADY = 0; w_cnt = 0; end
         M_AXI_ARREADY = M_AXI_ARVALID && (rnd ? ($urandom_range(1, 0) == 1) : 1'b1);

         if (s_b_pend && !M_AXI_BVALID) begin
            if (gate(b_cnt, b_delay)) begin
               M_AXI_BVALID = 1; M_AXI_BRESP = cfg_bresp; s_b_pend = 0;
            end else b_cnt++;
         end
         if (s_r_pend && !M_AXI_RVALID) begin
            if (gate(r_cnt, r_delay)) begin
               M_AXI_RVALID = 1; M_AXI_RDATA = s_mem[s_araddr[6:2]]; M_AXI_RRESP = cfg_rresp;
               s_r_pend = 0;
            end else r_cnt++;
         end

         hs_aw = M_AXI_AWVALID && M_AXI_AWREADY;
         if (hs_aw) s_awaddr = M_AXI_AWADDR;
         hs_w = M_AXI_WVALID && M_AXI_WREADY;
         if (hs_w) begin s_wdata = M_AXI_WDATA; s_wstrb = M_AXI_WSTRB; end
         hs_ar = M_AXI_ARVALID && M_AXI_ARREADY;
         if (hs_ar) s_araddr = M_AXI_ARADDR;
         hs_b = M_AXI_BVALID && M_AXI_BREADY;
         hs_r = M_AXI_RVALID && M_AXI_RREADY;
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge M_AXI_ACLK);
   endtask

   task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[a[6:2]][b*8 +: 8] = d[b*8 +: 8];
   endtask

   // Called on a falling edge; returns on the falling edge one cycle after acceptance (n+1).
   task automatic issue(input logic we, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      int k;
      CMD_WE = we; CMD_ADDR = a; CMD_WDATA = d; CMD_WSTRB = s; CMD_VALID = 1;
      k = 0;
      while (!CMD_READY && k < 50) begin @(negedge M_AXI_ACLK); k++; end
      check("cmd_accept_bound", CMD_READY, 1);
      @(negedge M_AXI_ACLK);
      CMD_VALID = 0;
   endtask

   // Called at n+1; returns lat such that RSP_VALID was first seen at n+lat.
   task automatic wait_rsp(output int lat);
      int k;
      k = 1;
      while (!RSP_VALID && k < 60) begin @(negedge M_AXI_ACLK); k++; end
      check("rsp_bound", RSP_VALID, 1);
      lat = k;
   endtask

   // ---------------- directed sequence ----------------
   int          lat;
   logic [31:0] wd;
   logic        b_we   [8];
   logic [15:0] b_addr [8];
   logic [31:0] b_data [8];
   logic [3:0]  b_strb [8];
   logic [31:0] b_exp  [8];
   int          acc_t  [8];
   int          idx, rc;
   bit          pend;

   initial begin
      M_AXI_ARST = 1; CMD_VALID = 0; CMD_WE = 0; CMD_ADDR = '0; CMD_WDATA = '0; CMD_WSTRB = '0;
      RSP_READY = 1;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0;
      M_AXI_RVALID = 0; M_AXI_BRESP = 0; M_AXI_RRESP = 0; M_AXI_RDATA = 0;
      for (int i = 0; i < 32; i++) begin s_mem[i] = '0; ref_mem[i] = '0; end
      s_mem[2] = 32'h12345678; ref_mem[2] = 32'h12345678;
      step(3);
      M_AXI_ARST = 0;
      step(1);

      // reset state
      check("rst_cmd_ready", CMD_READY, 1);
      check("rst_busy", BUSY, 0);
      check("rst_rsp_valid", RSP_VALID, 0);
      check("rst_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
      check("rst_readys", {M_AXI_BREADY, M_AXI_RREADY}, 0);
      check("rst_payload", {M_AXI_AWADDR, M_AXI_WSTRB, RSP_RESP}, 0);
      check("rst_rsp_rdata", RSP_RDATA, 0);
      check("rst_prot", {M_AXI_AWPROT, M_AXI_ARPROT}, 0);

      // zero-wait write
      issue(1, 16'h0004, 32'hDEADBEEF, 4'hF);
      ref_write(16'h0004, 32'hDEADBEEF, 4'hF);
      check("wr_awaddr", M_AXI_AWADDR, 16'h0004);
      check("wr_wdata", M_AXI_WDATA, 32'hDEADBEEF);
      check("wr_wstrb", M_AXI_WSTRB, 4'hF);
      check("wr_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
      check("wr_busy", {CMD_READY, BUSY}, 2'b01);
      step(1);
      check("wr_bready_n2", {M_AXI_BREADY, M_AXI_AWVALID, RSP_VALID}, 3'b100);
      step(1);
      check("wr_rsp_valid_n3", RSP_VALID, 1);
      check("wr_rsp_resp", RSP_RESP, 2'b00);
      check("wr_rsp_rdata", RSP_RDATA, 0);
      step(1);
      check("wr_idle_n4", {CMD_READY, BUSY, RSP_VALID}, 3'b100);

      // read with two wait cycles before RVALID
      r_delay = 2;
      issue(0, 16'h0008, 32'h0, 4'h0);
      check("rd_ar_n1", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 16'h0008});
      step(1);
      check("rd_ar_one_cycle", {M_AXI_ARVALID, M_AXI_RREADY}, 2'b01);
      step(2);
      check("rd_rsp_not_early", RSP_VALID, 0);
      step(1);
      check("rd_rsp_valid_n5", RSP_VALID, 1);
      check("rd_rdata", RSP_RDATA, 32'h12345678);
      check("rd_resp", RSP_RESP, 2'b00);
      r_delay = 0;
      step(1);

      // AW/W skew: W accepted three cycles before AW
      aw_delay = 3;
      wd = $urandom;
      issue(1, 16'h0010, wd, 4'hF);
      ref_write(16'h0010, wd, 4'hF);
      step(1);
      check("skew_w_first", {M_AXI_WVALID, M_AXI_AWVALID, M_AXI_BREADY}, 3'b010);
      check("skew_awaddr_n2", M_AXI_AWADDR, 16'h0010);
      step(2);
      check("skew_aw_held_n4", {M_AXI_AWVALID, M_AXI_BREADY}, 2'b10);
      check("skew_awaddr_n4", M_AXI_AWADDR, 16'h0010);
      step(1);
      check("skew_bready_n5", {M_AXI_AWVALID, M_AXI_BREADY}, 2'b01);
      step(1);
      check("skew_rsp_n6", {RSP_VALID, RSP_RESP}, 3'b100);
      aw_delay = 0;
      step(1);

      // response backpressure with SLVERR; a command offered while busy must wait
      cfg_bresp = 2'b10;
      RSP_READY = 0;
      wd = $urandom;
      issue(1, 16'h0020, wd, 4'b0101);
      ref_write(16'h0020, wd, 4'b0101);
      step(1);
      CMD_WE = 0; CMD_ADDR = 16'h0008; CMD_VALID = 1;
      step(1);
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_held", {RSP_VALID, RSP_RESP}, 3'b110);
         check("bp_rsp_rdata", RSP_RDATA, 0);
         check("bp_cmd_blocked", {CMD_READY, M_AXI_ARVALID}, 2'b00);
         step(1);
      end
      RSP_READY = 1;
      check("bp_cmd_ready_n8", CMD_READY, 0);
      step(1);
      check("bp_released_n9", {CMD_READY, RSP_VALID, M_AXI_ARVALID}, 3'b100);
      step(1);
      CMD_VALID = 0;
      check("bp_late_cmd_ar", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, 16'h0008});
      cfg_bresp = 2'b00;
      wait_rsp(lat);
      check("bp_late_cmd_data", RSP_RDATA, ref_mem[2]);
      step(1);

      // reset while waiting for B
      b_delay = 4;
      issue(1, 16'h0040, $urandom, 4'hF);
      step(1);
      check("rst_mid_in_wresp", M_AXI_BREADY, 1);
      M_AXI_ARST = 1;
      step(1);
      check("rst_mid_outputs", {M_AXI_BREADY, BUSY, CMD_READY, RSP_VALID, M_AXI_AWVALID},
            5'b00100);
      M_AXI_ARST = 0;
      b_delay = 0;
      step(1);
      issue(0, 16'h0004, 32'h0, 4'h0);
      wait_rsp(lat);
      check("rst_after_read_lat", lat, 3);
      check("rst_after_read_data", RSP_RDATA, ref_mem[1]);
      check("rst_after_read_resp", RSP_RESP, 2'b00);
      step(1);

      // back-to-back alternating write/read against a random-ready slave
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            b_we[i]   = 1;
            b_addr[i] = 16'(($urandom_range(15, 0)) * 4);
            b_data[i] = $urandom;
            b_strb[i] = 4'($urandom_range(15, 1));
            ref_write(b_addr[i], b_data[i], b_strb[i]);
            b_exp[i]  = '0;
         end else begin
            b_we[i]   = 0;
            b_addr[i] = b_addr[i-1];
            b_data[i] = $urandom;
            b_strb[i] = 4'hF;
            b_exp[i]  = ref_mem[b_addr[i][6:2]];
         end
      end
      rnd = 1;
      idx = 0; rc = 0; pend = 0;
      CMD_WE = b_we[0]; CMD_ADDR = b_addr[0]; CMD_WDATA = b_data[0]; CMD_WSTRB = b_strb[0];
      CMD_VALID = 1;
      for (int t = 0; t < 3000 && rc < 8; t++) begin
         if (pend) begin
            if (idx < 8) begin
               CMD_WE = b_we[idx]; CMD_ADDR = b_addr[idx];
               CMD_WDATA = b_data[idx]; CMD_WSTRB = b_strb[idx];
            end else CMD_VALID = 0;
            pend = 0;
         end
         if (CMD_VALID && CMD_READY && idx < 8) begin
            acc_t[idx] = t; idx++; pend = 1;
         end
         if (RSP_VALID && RSP_READY && rc < 8) begin
            check($sformatf("b2b_rdata_%0d", rc), RSP_RDATA, b_exp[rc]);
            check($sformatf("b2b_resp_%0d", rc), RSP_RESP, 2'b00);
            rc++;
         end
         @(negedge M_AXI_ACLK);
      end
      CMD_VALID = 0;
      rnd = 0;
      check("b2b_completed", rc, 8);
      for (int i = 0; i < 7; i++)
         if (i + 1 < idx)
            check($sformatf("b2b_period_%0d", i), ((acc_t[i+1] - acc_t[i]) >= 4), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
